// File: rtl/ctrl_unit_pipe_if.sv
// ctrl_unit_pipe_if: bundle between the control unit and the core datapath.
// The slave side is the control unit: it reads the FETCH instruction and the
// EX zero flag and drives the EX control word plus the fetch stall/redirect.
// stall_FETCH semantics: while high, the datapath holds PC and instruction_F
// for the next edge; the control unit injects a bubble into EX instead of the
// held instruction. There is no valid/ready pair; stall_FETCH is the only
// back-pressure signal.
interface ctrl_unit_pipe_if #(
  parameter int GPIO_CH = 1
);
  logic [31:0]        instruction_F;
  logic               zero_EX;
  logic [3:0]         op_EX;
  logic [4:0]         shamt_EX;
  logic [1:0]         regsel_EX;
  logic               enhilo_EX;
  logic               regwrite_EX;
  logic [1:0]         alu_src_EX;
  logic               rdrt_EX;
  logic [1:0]         pc_src_EX;
  logic               stall_FETCH;
  logic [GPIO_CH-1:0] gpio_we_EX;
  logic               illegal_EX;

  modport master (
    output instruction_F, zero_EX,
    input  op_EX, shamt_EX, regsel_EX, enhilo_EX, regwrite_EX, alu_src_EX,
           rdrt_EX, pc_src_EX, stall_FETCH, gpio_we_EX, illegal_EX
  );

  modport slave (
    input  instruction_F, zero_EX,
    output op_EX, shamt_EX, regsel_EX, enhilo_EX, regwrite_EX, alu_src_EX,
           rdrt_EX, pc_src_EX, stall_FETCH, gpio_we_EX, illegal_EX
  );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: pipelined MIPS control unit for the three-stage core.
// Decodes the FETCH instruction, registers the control word into EX, and
// produces branch redirect, fetch stall and bubble injection.
// Optional feature macro: HILO_INTERLOCK_EN adds the multiply busy tracker
// and stalls mfhi/mflo in FETCH until HI/LO is valid.
module ctrl_unit_pipe #(
  parameter int MULT_LAT = 4,
  parameter int GPIO_CH  = 1
) (
  input logic            clk,
  input logic            rst,
  ctrl_unit_pipe_if.slave bus
);
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_MULT  = 4'b0110;
  localparam logic [3:0] OP_MULTU = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1100;
  localparam logic [3:0] OP_SLTU  = 4'b1101;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rd, shamt;
  assign opcode = bus.instruction_F[31:26];
  assign rs     = bus.instruction_F[25:21];
  assign rd     = bus.instruction_F[15:11];
  assign shamt  = bus.instruction_F[10:6];
  assign funct  = bus.instruction_F[5:0];

  // Decoded (FETCH) control word
  logic [3:0]         d_op;
  logic [4:0]         d_shamt;
  logic [1:0]         d_regsel, d_alu_src;
  logic               d_enhilo, d_regwrite, d_rdrt, d_illegal;
  logic               d_beq, d_bne, d_mult, d_mfhilo;
  logic [GPIO_CH-1:0] d_gpio, gpio_sel;

  // EX-stage control word
  logic [3:0]         ex_op;
  logic [4:0]         ex_shamt;
  logic [1:0]         ex_regsel, ex_alu_src;
  logic               ex_enhilo, ex_regwrite, ex_rdrt, ex_illegal;
  logic               ex_beq, ex_bne;
  logic [GPIO_CH-1:0] ex_gpio;

  logic taken, hilo_stall, inject_bubble;

  // One-hot GPIO channel select from rs; out-of-range channels select nothing
  always_comb begin
    gpio_sel = '0;
    for (int i = 0; i < GPIO_CH; i++) gpio_sel[i] = (rs == 5'(i));
  end

  // Instruction decode of the FETCH instruction
  always_comb begin
    d_op = OP_AND; d_shamt = '0; d_regsel = '0; d_alu_src = '0;
    d_enhilo = 1'b0; d_regwrite = 1'b0; d_rdrt = 1'b0; d_illegal = 1'b0;
    d_beq = 1'b0; d_bne = 1'b0; d_mult = 1'b0; d_mfhilo = 1'b0;
    d_gpio = '0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin d_op = OP_ADD;  d_regwrite = 1'b1; end
          6'h22, 6'h23: begin d_op = OP_SUB;  d_regwrite = 1'b1; end
          6'h24:        begin d_op = OP_AND;  d_regwrite = 1'b1; end
          6'h25:        begin d_op = OP_OR;   d_regwrite = 1'b1; end
          6'h26:        begin d_op = OP_XOR;  d_regwrite = 1'b1; end
          6'h27:        begin d_op = OP_NOR;  d_regwrite = 1'b1; end
          6'h2a:        begin d_op = OP_SLT;  d_regwrite = 1'b1; end
          6'h2b:        begin d_op = OP_SLTU; d_regwrite = 1'b1; end
          6'h00: begin d_op = OP_SLL; d_shamt = shamt; d_regwrite = 1'b1; end
          6'h03: begin d_op = OP_SRA; d_shamt = shamt; d_regwrite = 1'b1; end
          6'h02: begin
            // srl to $0 with zero shift is the GPIO write; rt passes through
            if (shamt == 5'd0 && rd == 5'd0) begin
              d_gpio = gpio_sel;
              if (|gpio_sel) d_op = OP_SRL;
            end else begin
              d_op = OP_SRL; d_shamt = shamt; d_regwrite = 1'b1;
            end
          end
          6'h10: begin d_regsel = 2'd1; d_regwrite = 1'b1; d_mfhilo = 1'b1; end
          6'h12: begin d_regsel = 2'd2; d_regwrite = 1'b1; d_mfhilo = 1'b1; end
          6'h18: begin d_op = OP_MULT;  d_enhilo = 1'b1; d_mult = 1'b1; end
          6'h19: begin d_op = OP_MULTU; d_enhilo = 1'b1; d_mult = 1'b1; end
          default: d_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin d_op = OP_ADD;  d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'h0a:        begin d_op = OP_SLT;  d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'h0b:        begin d_op = OP_SLTU; d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'h0c:        begin d_op = OP_AND;  d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'h0d:        begin d_op = OP_OR;   d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'h0e:        begin d_op = OP_XOR;  d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'h0f: begin
        d_op = OP_SLL; d_shamt = 5'd16; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1;
      end
      6'h04: begin d_op = OP_SUB; d_beq = 1'b1; end
      6'h05: begin d_op = OP_SUB; d_bne = 1'b1; end
      default: d_illegal = 1'b1;
    endcase
  end

  assign taken = (ex_bne & ~bus.zero_EX) | (ex_beq & bus.zero_EX);

`ifdef HILO_INTERLOCK_EN
  logic [3:0] mult_cnt;
  assign hilo_stall = d_mfhilo & (mult_cnt != 4'd0);

  // Multiply busy counter: reload on every mult entering EX, else count down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mult_cnt <= 4'd0;
    else if (!inject_bubble && d_mult) mult_cnt <= 4'(MULT_LAT - 1);
    else if (mult_cnt != 4'd0) mult_cnt <= mult_cnt - 4'd1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = d_mult ^ d_mfhilo ^ (MULT_LAT > 1);
  assign hilo_stall = 1'b0;
`endif

  // A taken branch flushes the wrong-path FETCH word; an interlock holds it
  assign inject_bubble = taken | hilo_stall;

  // EX control word register: bubble on reset, flush or interlock
  always_ff @(posedge clk or posedge rst) begin
    if (rst || inject_bubble) begin
      ex_op <= '0; ex_shamt <= '0; ex_regsel <= '0; ex_alu_src <= '0;
      ex_enhilo <= 1'b0; ex_regwrite <= 1'b0; ex_rdrt <= 1'b0;
      ex_illegal <= 1'b0; ex_beq <= 1'b0; ex_bne <= 1'b0; ex_gpio <= '0;
    end else begin
      ex_op <= d_op; ex_shamt <= d_shamt; ex_regsel <= d_regsel;
      ex_alu_src <= d_alu_src; ex_enhilo <= d_enhilo;
      ex_regwrite <= d_regwrite; ex_rdrt <= d_rdrt; ex_illegal <= d_illegal;
      ex_beq <= d_beq; ex_bne <= d_bne; ex_gpio <= d_gpio;
    end
  end

  logic unused_bits;
  assign unused_bits = ^bus.instruction_F[20:16];

  assign bus.op_EX       = ex_op;
  assign bus.shamt_EX    = ex_shamt;
  assign bus.regsel_EX   = ex_regsel;
  assign bus.enhilo_EX   = ex_enhilo;
  assign bus.regwrite_EX = ex_regwrite;
  assign bus.alu_src_EX  = ex_alu_src;
  assign bus.rdrt_EX     = ex_rdrt;
  assign bus.gpio_we_EX  = ex_gpio;
  assign bus.illegal_EX  = ex_illegal;
  assign bus.pc_src_EX   = {1'b0, taken};
  assign bus.stall_FETCH = inject_bubble;
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: directed bench for ctrl_unit_pipe (MULT_LAT=4, GPIO_CH=4).
module tb_ctrl_unit_pipe;
  localparam int GPIO_CH = 4;
  localparam int W = 17 + GPIO_CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [4:0] ra, rb, rc;

  ctrl_unit_pipe_if #(.GPIO_CH(GPIO_CH)) bus();

  ctrl_unit_pipe #(.MULT_LAT(4), .GPIO_CH(GPIO_CH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ew(logic [3:0] op, logic [4:0] sh, logic [1:0] rs,
                                      logic eh, logic rw, logic [1:0] as, logic rd,
                                      logic [GPIO_CH-1:0] g, logic il);
    return {op, sh, rs, eh, rw, as, rd, g, il};
  endfunction

  function automatic logic [W-1:0] r_word(logic [3:0] op, logic [4:0] sh);
    return ew(op, sh, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0);
  endfunction

  function automatic logic [W-1:0] i_word(logic [3:0] op, logic [4:0] sh, logic [1:0] as);
    return ew(op, sh, 2'd0, 1'b0, 1'b1, as, 1'b1, '0, 1'b0);
  endfunction

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.op_EX, bus.shamt_EX, bus.regsel_EX, bus.enhilo_EX, bus.regwrite_EX,
            bus.alu_src_EX, bus.rdrt_EX, bus.gpio_we_EX, bus.illegal_EX};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one FETCH word; check the combinational redirect/stall for the
  // current EX word, then the EX word this instruction should produce
  task automatic step(input string tag, input logic [31:0] ins, input logic z,
                      input logic [W-1:0] exp_word, input logic exp_stall,
                      input logic exp_pc);
    logic [W-1:0] e;
    @(negedge clk);
    bus.instruction_F = ins;
    bus.zero_EX = z;
    #1;
    chk({tag, ".stall"}, 32'(bus.stall_FETCH), 32'(exp_stall));
    chk({tag, ".pc_src"}, 32'(bus.pc_src_EX), {31'd0, exp_pc});
    exp_q.push_back(exp_word);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_fail++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(observed()), 32'(e));
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".word"}, 32'(observed()), 32'd0);
    chk({tag, ".stall"}, 32'(bus.stall_FETCH), 32'd0);
    chk({tag, ".pc_src"}, 32'(bus.pc_src_EX), 32'd0);
  endtask

  // Pulse reset asynchronously between edges, then release with an add in FETCH
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    all_zero(tag);
    bus.instruction_F = r_ins(ra, rb, rc, 5'd0, 6'h20);
    bus.zero_EX = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w_add, w_br, w_mult, w_multu, w_mfhi, w_mflo;
    logic [31:0] add_i, mfhi_i, mflo_i, mult_i, multu_i, bne_i, beq_i;
    ra = 5'($urandom_range(1, 31));
    rb = 5'($urandom_range(1, 31));
    rc = 5'($urandom_range(1, 31));
    w_add   = r_word(4'b0100, 5'd0);
    w_br    = ew(4'b0101, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    w_mult  = ew(4'b0110, 5'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    w_multu = ew(4'b0111, 5'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    w_mfhi  = ew(4'b0000, 5'd0, 2'd1, 1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0);
    w_mflo  = ew(4'b0000, 5'd0, 2'd2, 1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0);
    add_i   = r_ins(ra, rb, rc, 5'd0, 6'h20);
    mfhi_i  = r_ins(5'd0, 5'd0, rc, 5'd0, 6'h10);
    mflo_i  = r_ins(5'd0, 5'd0, rc, 5'd0, 6'h12);
    mult_i  = r_ins(ra, rb, 5'd0, 5'd0, 6'h18);
    multu_i = r_ins(ra, rb, 5'd0, 5'd0, 6'h19);
    bne_i   = i_ins(6'h05, ra, rb, 16'h0010);
    beq_i   = i_ins(6'h04, ra, rb, 16'hfff0);

    // Reset
    bus.instruction_F = add_i;
    bus.zero_EX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream, then the add decodes again
    step("add", add_i, 1'b0, w_add, 1'b0, 1'b0);
    async_reset("async_rst");
    step("add_after_rst", add_i, 1'b0, w_add, 1'b0, 1'b0);

    // lui / ori and the rest of the decode set
    step("lui", i_ins(6'h0f, 5'd0, rb, 16'h1234), 1'b0, i_word(4'b1000, 5'd16, 2'd2), 1'b0, 1'b0);
    step("ori", i_ins(6'h0d, rb, rb, 16'h5678), 1'b0, i_word(4'b0001, 5'd0, 2'd2), 1'b0, 1'b0);
    step("addi", i_ins(6'h08, ra, rb, 16'hffff), 1'b0, i_word(4'b0100, 5'd0, 2'd1), 1'b0, 1'b0);
    step("addiu", i_ins(6'h09, ra, rb, 16'h0001), 1'b0, i_word(4'b0100, 5'd0, 2'd1), 1'b0, 1'b0);
    step("andi", i_ins(6'h0c, ra, rb, 16'h00ff), 1'b0, i_word(4'b0000, 5'd0, 2'd2), 1'b0, 1'b0);
    step("xori", i_ins(6'h0e, ra, rb, 16'h0f0f), 1'b0, i_word(4'b0011, 5'd0, 2'd2), 1'b0, 1'b0);
    step("slti", i_ins(6'h0a, ra, rb, 16'h8000), 1'b0, i_word(4'b1100, 5'd0, 2'd1), 1'b0, 1'b0);
    step("sltiu", i_ins(6'h0b, ra, rb, 16'h0003), 1'b0, i_word(4'b1101, 5'd0, 2'd1), 1'b0, 1'b0);
    step("addu", r_ins(ra, rb, rc, 5'd0, 6'h21), 1'b0, r_word(4'b0100, 5'd0), 1'b0, 1'b0);
    step("sub", r_ins(ra, rb, rc, 5'd0, 6'h22), 1'b0, r_word(4'b0101, 5'd0), 1'b0, 1'b0);
    step("subu", r_ins(ra, rb, rc, 5'd0, 6'h23), 1'b0, r_word(4'b0101, 5'd0), 1'b0, 1'b0);
    step("and", r_ins(ra, rb, rc, 5'd0, 6'h24), 1'b0, r_word(4'b0000, 5'd0), 1'b0, 1'b0);
    step("or", r_ins(ra, rb, rc, 5'd0, 6'h25), 1'b0, r_word(4'b0001, 5'd0), 1'b0, 1'b0);
    step("xor", r_ins(ra, rb, rc, 5'd0, 6'h26), 1'b0, r_word(4'b0011, 5'd0), 1'b0, 1'b0);
    step("nor", r_ins(ra, rb, rc, 5'd0, 6'h27), 1'b0, r_word(4'b0010, 5'd0), 1'b0, 1'b0);
    step("slt", r_ins(ra, rb, rc, 5'd0, 6'h2a), 1'b0, r_word(4'b1100, 5'd0), 1'b0, 1'b0);
    step("sltu", r_ins(ra, rb, rc, 5'd0, 6'h2b), 1'b0, r_word(4'b1101, 5'd0), 1'b0, 1'b0);
    step("sll", r_ins(5'd0, rb, rc, 5'd7, 6'h00), 1'b0, r_word(4'b1000, 5'd7), 1'b0, 1'b0);
    step("srl", r_ins(5'd0, rb, 5'd0, 5'd3, 6'h02), 1'b0, r_word(4'b1001, 5'd3), 1'b0, 1'b0);
    step("srl_rd", r_ins(5'd2, rb, rc, 5'd0, 6'h02), 1'b0, r_word(4'b1001, 5'd0), 1'b0, 1'b0);
    step("sra", r_ins(5'd0, rb, rc, 5'd31, 6'h03), 1'b0, r_word(4'b1010, 5'd31), 1'b0, 1'b0);

    // Branches: bne taken flushes one FETCH word, not-taken does not
    step("bne", bne_i, 1'b0, w_br, 1'b0, 1'b0);
    step("bne_flush", add_i, 1'b0, '0, 1'b1, 1'b1);
    step("bne_after", add_i, 1'b0, w_add, 1'b0, 1'b0);
    step("bne_nt", bne_i, 1'b0, w_br, 1'b0, 1'b0);
    step("bne_nt_next", add_i, 1'b1, w_add, 1'b0, 1'b0);
    step("beq", beq_i, 1'b0, w_br, 1'b0, 1'b0);
    step("beq_flush", add_i, 1'b1, '0, 1'b1, 1'b1);
    step("beq_after", add_i, 1'b1, w_add, 1'b0, 1'b0);
    step("beq_nt", beq_i, 1'b0, w_br, 1'b0, 1'b0);
    step("beq_nt_next", add_i, 1'b0, w_add, 1'b0, 1'b0);

    // GPIO writes and out-of-range channels
    step("gpio2", r_ins(5'd2, rb, 5'd0, 5'd0, 6'h02), 1'b0,
         ew(4'b1001, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0), 1'b0, 1'b0);
    step("gpio0", r_ins(5'd0, rb, 5'd0, 5'd0, 6'h02), 1'b0,
         ew(4'b1001, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b0), 1'b0, 1'b0);
    step("gpio3", r_ins(5'd3, rb, 5'd0, 5'd0, 6'h02), 1'b0,
         ew(4'b1001, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1000, 1'b0), 1'b0, 1'b0);
    step("gpio4", r_ins(5'd4, rb, 5'd0, 5'd0, 6'h02), 1'b0, '0, 1'b0, 1'b0);
    step("gpio5", r_ins(5'd5, rb, 5'd0, 5'd0, 6'h02), 1'b0, '0, 1'b0, 1'b0);

    // Illegal encodings
    step("illegal_op", {6'h3f, ra, rb, 16'h1234}, 1'b0,
         ew(4'b0000, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b1), 1'b0, 1'b0);
    step("illegal_fn", r_ins(ra, rb, rc, 5'd0, 6'h3f), 1'b0,
         ew(4'b0000, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b1), 1'b0, 1'b0);
    step("add_after_ill", add_i, 1'b0, w_add, 1'b0, 1'b0);

    // mult then mfhi
    step("mult", mult_i, 1'b0, w_mult, 1'b0, 1'b0);
`ifdef HILO_INTERLOCK_EN
    step("mfhi_wait1", mfhi_i, 1'b0, '0, 1'b1, 1'b0);
    step("mfhi_wait2", mfhi_i, 1'b0, '0, 1'b1, 1'b0);
    step("mfhi_wait3", mfhi_i, 1'b0, '0, 1'b1, 1'b0);
`endif
    step("mfhi", mfhi_i, 1'b0, w_mfhi, 1'b0, 1'b0);

    // Counter keeps running through a branch flush
    step("mult_b", mult_i, 1'b0, w_mult, 1'b0, 1'b0);
    step("bne_b", bne_i, 1'b0, w_br, 1'b0, 1'b0);
    step("flush_b", mfhi_i, 1'b0, '0, 1'b1, 1'b1);
`ifdef HILO_INTERLOCK_EN
    step("mfhi_b_wait", mfhi_i, 1'b0, '0, 1'b1, 1'b0);
`endif
    step("mfhi_b", mfhi_i, 1'b0, w_mfhi, 1'b0, 1'b0);

    // A second multiply reloads the counter
    step("mult_c", mult_i, 1'b0, w_mult, 1'b0, 1'b0);
    step("add_c", add_i, 1'b0, w_add, 1'b0, 1'b0);
    step("multu_c", multu_i, 1'b0, w_multu, 1'b0, 1'b0);
`ifdef HILO_INTERLOCK_EN
    step("mflo_c_wait1", mflo_i, 1'b0, '0, 1'b1, 1'b0);
    step("mflo_c_wait2", mflo_i, 1'b0, '0, 1'b1, 1'b0);
    step("mflo_c_wait3", mflo_i, 1'b0, '0, 1'b1, 1'b0);
`endif
    step("mflo_c", mflo_i, 1'b0, w_mflo, 1'b0, 1'b0);

    // Reset mid-multiply abandons the count
    step("mult_d", mult_i, 1'b0, w_mult, 1'b0, 1'b0);
    async_reset("rst_mult");
    step("mflo_d", mflo_i, 1'b0, w_mflo, 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      n_vec++; n_fail++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_unit_pipe.md
# ctrl_unit_pipe

Pipelined MIPS control unit for the three-stage core: decodes the FETCH-stage instruction, registers the control word into EX, and generates branch redirect, fetch stall and bubble injection. Generalises the single-cycle decoder with a multi-cycle multiply busy tracker, a parametrised GPIO write-channel count and a full R/I-type decode set. Sits between the instruction register and the EX-stage datapath (ALU, HI/LO, register-file write port, GPIO).

## Interface
- MULT_LAT, 4, multiply latency in cycles (1..15); HI/LO valid MULT_LAT cycles after mult/multu enters EX
- GPIO_CH, 1, number of GPIO write channels (1..8)

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- instruction_F  in  32  instruction in FETCH
- zero_EX  in  1  ALU zero flag for the instruction in EX
- op_EX  out  4  ALU op: AND 0000, OR 0001, NOR 0010, XOR 0011, ADD 0100, SUB 0101, MULT 0110, MULTU 0111, SLL 1000, SRL 1001, SRA 1010, SLT 1100, SLTU 1101
- shamt_EX  out  5  shift amount (instr[10:6] for sll/srl/sra, 16 for lui, 0 otherwise)
- regsel_EX  out  2  1 mfhi, 2 mflo, 0 otherwise
- enhilo_EX  out  1  HI/LO write enable (mult, multu)
- regwrite_EX  out  1  register-file write enable
- alu_src_EX  out  2  0 rt, 1 sign-ext imm, 2 zero-ext imm
- rdrt_EX  out  1  1 = destination is rt
- pc_src_EX  out  2  0 sequential, 1 branch target
- stall_FETCH  out  1  hold PC and instruction_F
- gpio_we_EX  out  GPIO_CH  one-hot GPIO write enable
- illegal_EX  out  1  undecoded instruction in EX

## Operation
- Decode set: R-type add/addu/sub/subu/and/or/nor/xor/slt/sltu/sll/srl/sra/mult/multu/mfhi/mflo; I-type addi/addiu (alu_src 1), andi/ori/xori (alu_src 2), slti/sltiu, lui (SLL, shamt 16, alu_src 2), beq, bne.
- All I-type writers: rdrt_EX=1, regwrite_EX=1. beq/bne: op SUB, regwrite 0.
- GPIO write: srl with instr[10:6]==0 and instr[15:11]==0; channel = instr[25:21]; gpio_we_EX bit set only if channel < GPIO_CH, regwrite_EX=0. Channel >= GPIO_CH decodes as NOP, not illegal.
- Unlisted opcode/funct: bubble control word with illegal_EX=1.
- Bubble: all control outputs 0 (op_EX=0000, no writes, illegal_EX=0).
- Branch: taken when (bne & ~zero_EX) | (beq & zero_EX) for instruction in EX; pc_src_EX=1, stall_FETCH=1, and the next EX word is a bubble (flush of wrong-path FETCH instruction).
- Multiply tracker: counter loads MULT_LAT-1 when mult/multu enters EX; decrements to 0; busy = counter != 0. A second mult while busy reloads the counter.
- Priority when several apply: reset > branch flush > HI/LO interlock > normal advance.

## Timing
- Decode to EX: 1 cycle; control outputs are flops except pc_src_EX and stall_FETCH, which are combinational from EX flops, counter and zero_EX.
- Reset: every output 0, counter 0, EX word = bubble; reset mid-multiply abandons the count.
- Branch taken: stall_FETCH high exactly one cycle; bubble in EX the following cycle; redirect PC fetched the cycle after.
- HI/LO interlock (see Configuration): mfhi/mflo in FETCH while busy -> stall_FETCH=1, bubble enters EX; mfhi/mflo enters EX on the first edge with counter==0.
- Counter keeps decrementing during flush and stall cycles.

## Configuration
- HILO_INTERLOCK_EN defined: multiply tracker and mfhi/mflo stall as above.
- Undefined: tracker removed, mfhi/mflo never stall; software schedules MULT_LAT-1 independent instructions after mult. MULT_LAT ignored.

## Test plan
- Reset asserted mid-stream with instruction_F=add -> all outputs 0 immediately (async); after release, add at instruction_F -> op_EX=0100, regwrite_EX=1 one cycle later.
- lui then ori in FETCH -> EX shows op 1000/shamt 16/alu_src 2/rdrt 1, then op 0001/alu_src 2/rdrt 1.
- bne in EX with zero_EX=0 -> pc_src_EX=1, stall_FETCH=1 one cycle, next EX word bubble; zero_EX=1 -> no redirect, no bubble.
- HILO_INTERLOCK_EN, MULT_LAT=4: mult then mfhi -> three bubble cycles, mfhi in EX with regsel_EX=1 on fourth cycle after mult; undefined -> mfhi in EX next cycle.
- GPIO_CH=4: srl with rs=2, rd=0, shamt=0 -> gpio_we_EX=0100, regwrite_EX=0; rs=5 -> gpio_we_EX=0, illegal_EX=0.
- Opcode 111111 -> illegal_EX=1, all write enables 0.
